synapse_row_fetcher: RTL and testbench
======================================

# synapse_row_fetcher

Upstream address generator and downstream stream formatter for `synapse_memory`. It accepts presynaptic spike events, queues them in a small FIFO, and sweeps each spiking neuron's weight row (addresses `pre*N_POST .. pre*N_POST+N_POST-1`) through the memory's synchronous read port. It emits one (post index, weight) beat per cycle toward the neuron update stage, and pulses `o_syn_last` on each row's final beat.

## Interface
- `N_PRE`, 100: number of presynaptic neurons.
- `N_POST`, 100: number of postsynaptic neurons (row length), ≥ 2.
- `PRE_WIDTH`, 7: width of presynaptic index.
- `POST_WIDTH`, 7: width of postsynaptic index.
- `ADDR_WIDTH`, 14: memory address width; `N_PRE*N_POST` ≤ 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8: weight width, passed through unmodified.
- `FIFO_DEPTH`, 4: event queue depth, power of two.

Ports:
- `clk`  in  1  the single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_spike_valid`  in  1  spike event offered.
- `i_spike_pre`  in  PRE_WIDTH  presynaptic index of the event.
- `o_spike_ready`  out  1  event accepted when `i_spike_valid` and `o_spike_ready` are both high at a rising edge.
- `o_read_addr`  out  ADDR_WIDTH  registered read address to memory.
- `i_read_weight`  in  DATA_WIDTH  memory read data, one-cycle synchronous latency.
- `o_syn_valid`  out  1  output beat valid (no backpressure).
- `o_syn_post`  out  POST_WIDTH  postsynaptic index of the beat.
- `o_syn_weight`  out  DATA_WIDTH  weight of the beat.
- `o_syn_last`  out  1  beat is `post = N_POST-1`.
- `o_err`  out  1  one-cycle pulse: dequeued event with `pre ≥ N_PRE`.
- `o_busy`  out  1  FIFO non-empty, FETCH active, or pipeline beats in flight.

## Operation
- FIFO: `o_spike_ready = !full`. A push is refused when full, even if a pop occurs in the same cycle. Push and pop in the same cycle on a non-full, non-empty FIFO keep the count unchanged.
- FSM states: IDLE, FETCH.
- IDLE with FIFO non-empty: pop the event.
  - Valid index: `base <= pre*N_POST`, `o_read_addr <= pre*N_POST`, `post_cnt <= 0`, go to FETCH.
  - Invalid index: pulse `o_err`, drop the event, stay in IDLE.
- FETCH: each edge, `post_cnt++` and `o_read_addr <= base + post_cnt + 1`.
- FETCH, at the edge where `post_cnt = N_POST-1`:
  - If the FIFO is non-empty, pop and load the next row with no bubble. An invalid popped index pulses `o_err` and the FSM goes to IDLE.
  - Otherwise go to IDLE.
- Address arithmetic: product is `ADDR_WIDTH` bits with no wrap, guaranteed by the parameter constraint. `post_cnt` never exceeds `N_POST-1`.
- Tag pipeline: 2 stages carry `{valid, post, last}`. Stage 0 is loaded when `o_read_addr` is loaded. Stage 1 is loaded the following edge, when memory has captured the address. Output registers capture `i_read_weight` together with stage 1 tags.
- IDLE: `o_read_addr` holds its last value; stage-0 valid is 0.

## Timing
- Reset values: `o_spike_ready=0` during reset and 1 after; `o_read_addr=0`, `o_syn_valid=0`, `o_syn_post=0`, `o_syn_weight=0`, `o_syn_last=0`, `o_err=0`, `o_busy=0`. FIFO is emptied and the FSM enters IDLE.
- Latency, empty FIFO and IDLE:
  - Event accepted at edge E0.
  - Popped and address driven at E1.
  - Memory captures at E2.
  - First `o_syn_valid` high after E3.
  - Then N_POST consecutive valid beats.
- Back-to-back rows produce a continuous valid stream: the last beat of row k is immediately followed by beat 0 of row k+1.
- `o_err` is asserted the cycle after the pop edge of an invalid event.
- Reset asserted mid-row: all state clears at that edge. No further beats are emitted, `o_syn_valid=0` from the next cycle, and queued events are lost.
- `o_busy` falls the cycle after the last beat is presented.

## Test plan
Use `N_PRE=4`, `N_POST=3`, `FIFO_DEPTH=4`. The memory model returns `mem[a]=a+16`.
- Single spike `pre=2` into idle block -> addresses 6,7,8 on consecutive cycles. Beats `(post,weight) = (0,22),(1,23),(2,24)`, first beat 3 cycles after accept edge, `o_syn_last` on the third beat only.
- Spikes 0,3 on consecutive cycles -> 6 contiguous beats with weights 16,17,18,25,26,27 and no gap. `o_syn_last` on beats 3 and 6.
- Hold `i_spike_valid` with `pre=1` for 10 cycles -> `o_spike_ready` drops after the FIFO fills (4 queued plus 1 in FETCH). Every accepted event yields exactly 3 beats of 19,20,21, and the accepted count matches ready-high cycles.
- Spike `pre=5` then `pre=1` -> one `o_err` pulse, no beats for 5, then beats 19,20,21.
- `rst` asserted on the second beat of a row -> `o_syn_valid=0` from the next cycle, `o_busy=0`, and a later spike `pre=0` produces 16,17,18 with nominal latency.

Source files
------------

// File: rtl/synapse_row_fetcher.sv
// Spike-event queue plus row sweeper for synapse_memory: each accepted presynaptic
// index becomes N_POST consecutive (post, weight) beats, reads tagged through a 2-stage pipe.
module synapse_row_fetcher #(
  parameter int N_PRE      = 100,
  parameter int N_POST     = 100,
  parameter int PRE_WIDTH  = 7,
  parameter int POST_WIDTH = 7,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_spike_valid,
  input  logic [PRE_WIDTH-1:0]  i_spike_pre,
  output logic                  o_spike_ready,
  output logic [ADDR_WIDTH-1:0] o_read_addr,
  input  logic [DATA_WIDTH-1:0] i_read_weight,
  output logic                  o_syn_valid,
  output logic [POST_WIDTH-1:0] o_syn_post,
  output logic [DATA_WIDTH-1:0] o_syn_weight,
  output logic                  o_syn_last,
  output logic                  o_err,
  output logic                  o_busy
);
  // Handshake: an event transfers on a rising edge where i_spike_valid && o_spike_ready;
  // the output stream has no backpressure and is valid for exactly one cycle per beat.

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]          FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PRE_WIDTH:0]      N_PRE_P   = (PRE_WIDTH+1)'(N_PRE);
  localparam logic [ADDR_WIDTH-1:0]   N_POST_A  = ADDR_WIDTH'(N_POST);
  localparam logic [POST_WIDTH-1:0]   POST_LAST = POST_WIDTH'(N_POST-1);

  typedef enum logic [0:0] {IDLE, FETCH} state_t;

  state_t                  state_q;
  logic [PRE_WIDTH-1:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]          count_q, count_d;
  logic                    ready_q;
  logic [ADDR_WIDTH-1:0]   base_q, addr_q, row_base;
  logic [POST_WIDTH-1:0]   post_cnt_q;
  logic                    s0_valid_q, s0_last_q, s1_valid_q, s1_last_q;
  logic [POST_WIDTH-1:0]   s0_post_q, s1_post_q;
  logic                    syn_valid_q, syn_last_q, err_q;
  logic [POST_WIDTH-1:0]   syn_post_q;
  logic [DATA_WIDTH-1:0]   syn_weight_q;
  logic                    fifo_empty, row_end, push, pop, pop_bad, load_row;
  logic [PRE_WIDTH-1:0]    head_pre;

  always_comb begin
    fifo_empty = (count_q == '0);
    head_pre   = fifo_mem_q[rd_ptr_q];
    row_end    = (state_q == FETCH) && (post_cnt_q == POST_LAST);
    push       = i_spike_valid && ready_q;
    pop        = !fifo_empty && ((state_q == IDLE) || row_end);
    pop_bad    = ({1'b0, head_pre} >= N_PRE_P);
    load_row   = pop && !pop_bad;
    count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    row_base   = ADDR_WIDTH'(head_pre) * N_POST_A;
  end

  // Ready is registered so it reads 0 throughout reset; fullness uses the current
  // count, so a push into a full queue is refused even when a pop happens that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= i_spike_pre;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ready_q <= (count_d != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      addr_q       <= '0;
      post_cnt_q   <= '0;
      s0_valid_q   <= 1'b0;
      s0_post_q    <= '0;
      s0_last_q    <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_post_q    <= '0;
      s1_last_q    <= 1'b0;
      syn_valid_q  <= 1'b0;
      syn_post_q   <= '0;
      syn_weight_q <= '0;
      syn_last_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q      <= pop && pop_bad;
      s0_valid_q <= 1'b0;
      if (load_row) begin
        state_q    <= FETCH;
        base_q     <= row_base;
        addr_q     <= row_base;
        post_cnt_q <= '0;
        s0_valid_q <= 1'b1;
        s0_post_q  <= '0;
        s0_last_q  <= (POST_LAST == '0);
      end else if ((state_q == FETCH) && !row_end) begin
        post_cnt_q <= post_cnt_q + POST_WIDTH'(1);
        addr_q     <= base_q + ADDR_WIDTH'(post_cnt_q) + ADDR_WIDTH'(1);
        s0_valid_q <= 1'b1;
        s0_post_q  <= post_cnt_q + POST_WIDTH'(1);
        s0_last_q  <= ((post_cnt_q + POST_WIDTH'(1)) == POST_LAST);
      end else begin
        state_q <= IDLE;
      end
      // Stage 1 lines up with the edge where memory samples the address.
      s1_valid_q  <= s0_valid_q;
      s1_post_q   <= s0_post_q;
      s1_last_q   <= s0_last_q;
      syn_valid_q <= s1_valid_q;
      syn_last_q  <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        syn_post_q   <= s1_post_q;
        syn_weight_q <= i_read_weight;
      end
    end
  end

  assign o_spike_ready = ready_q;
  assign o_read_addr   = addr_q;
  assign o_syn_valid   = syn_valid_q;
  assign o_syn_post    = syn_post_q;
  assign o_syn_weight  = syn_weight_q;
  assign o_syn_last    = syn_last_q;
  assign o_err         = err_q;
  assign o_busy        = !fifo_empty || (state_q == FETCH) || s0_valid_q || s1_valid_q
                         || syn_valid_q;

endmodule

// File: tb/tb_synapse_row_fetcher.sv
// Bench for synapse_row_fetcher with N_PRE=4, N_POST=3; memory returns mem[a]=a+16.
module tb_synapse_row_fetcher;
  logic       clk = 1'b0;
  logic       rst;
  logic       i_spike_valid;
  logic [2:0] i_spike_pre;
  logic       o_spike_ready;
  logic [3:0] o_read_addr;
  logic [7:0] i_read_weight;
  logic       o_syn_valid;
  logic [1:0] o_syn_post;
  logic [7:0] o_syn_weight;
  logic       o_syn_last;
  logic       o_err;
  logic       o_busy;

  logic [10:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int exp_err = 0;
  int err_seen = 0;

  synapse_row_fetcher #(
    .N_PRE(4), .N_POST(3), .PRE_WIDTH(3), .POST_WIDTH(2),
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_spike_valid(i_spike_valid), .i_spike_pre(i_spike_pre), .o_spike_ready(o_spike_ready),
    .o_read_addr(o_read_addr), .i_read_weight(i_read_weight),
    .o_syn_valid(o_syn_valid), .o_syn_post(o_syn_post), .o_syn_weight(o_syn_weight),
    .o_syn_last(o_syn_last), .o_err(o_err), .o_busy(o_busy)
  );

  // clock/reset block and memory model
  always #5 clk = ~clk;

  always @(posedge clk) i_read_weight <= 8'(o_read_addr) + 8'd16;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (o_err) err_seen++;
    if (o_syn_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got post=%0d weight=%0d last=%0d, queue empty",
                 o_syn_post, o_syn_weight, o_syn_last);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if ({o_syn_post, o_syn_weight, o_syn_last} !== e) begin
          bad++;
          $display("FAIL beat: got post=%0d weight=%0d last=%0d, want post=%0d weight=%0d last=%0d",
                   o_syn_post, o_syn_weight, o_syn_last, e[10:9], e[8:1], e[0]);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic expect_event(input logic [2:0] pre);
    if (pre < 3'd4) begin
      for (int p = 0; p < 3; p++)
        exp_q.push_back({2'(p), 8'(int'(pre) * 3 + p + 16), (p == 2)});
    end else begin
      exp_err++;
    end
  endtask

  // driver: enter at a negedge, leave at the negedge after the accept edge
  task automatic spike(input logic [2:0] pre);
    bit ok;
    ok = 1'b0;
    i_spike_valid = 1'b1;
    i_spike_pre   = pre;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (o_spike_ready) begin
        @(posedge clk);
        ok = 1'b1;
        expect_event(pre);
      end
      @(negedge clk);
    end
    if (!ok) check("spike_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (!o_busy && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  // called right after spike() returns on an idle block with an empty queue
  task automatic row_latency(input int a0, input string tag);
    @(posedge clk); #1;
    check({tag, "_addr0"}, int'(o_read_addr), a0);
    @(posedge clk); #1;
    check({tag, "_addr1"}, int'(o_read_addr), a0 + 1);
    check({tag, "_early_valid"}, int'(o_syn_valid), 0);
    @(posedge clk); #1;
    check({tag, "_addr2"}, int'(o_read_addr), a0 + 2);
    check({tag, "_first_valid"}, int'(o_syn_valid), 1);
  endtask

  initial begin
    int acc;
    int run;
    bit seen;
    rst = 1'b1;
    i_spike_valid = 1'b0;
    i_spike_pre = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(o_spike_ready), 0);
    check("rst_addr", int'(o_read_addr), 0);
    check("rst_valid", int'(o_syn_valid), 0);
    check("rst_post_weight_last", int'({o_syn_post, o_syn_weight, o_syn_last}), 0);
    check("rst_err_busy", int'({o_err, o_busy}), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", int'(o_spike_ready), 1);
    @(negedge clk);

    // single row pre=2: addresses 6,7,8, beats 22,23,24
    spike(3'd2);
    i_spike_valid = 1'b0;
    row_latency(6, "row2");
    wait_idle();

    // back-to-back rows 0 and 3: six contiguous beats
    spike(3'd0);
    spike(3'd3);
    i_spike_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (o_syn_valid) seen = 1'b1;
    end
    run = 0;
    if (seen) begin
      run = 1;
      for (int n = 0; n < 6; n++) begin
        @(negedge clk);
        if (o_syn_valid && run == n + 1) run++;
      end
    end
    check("contiguous_beats", run, 6);
    wait_idle();

    // hold valid with pre=1 for 10 cycles: accepts on 7 edges, ready low at the 7th
    acc = 0;
    i_spike_valid = 1'b1;
    i_spike_pre = 3'd1;
    for (int c = 0; c < 10; c++) begin
      if (c == 6) check("ready_low_when_full", int'(o_spike_ready), 0);
      if (o_spike_ready) begin
        acc++;
        expect_event(3'd1);
      end
      @(posedge clk);
      @(negedge clk);
    end
    i_spike_valid = 1'b0;
    check("accepted_count", acc, 7);
    wait_idle();

    // invalid index then valid one
    spike(3'd5);
    spike(3'd1);
    i_spike_valid = 1'b0;
    wait_idle();
    check("err_pulses", err_seen, exp_err);
    check("err_pulses_const", err_seen, 1);

    // reset on second beat of a row
    spike(3'd1);
    i_spike_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (o_syn_valid && o_syn_post == 2'd1) seen = 1'b1;
    end
    check("second_beat_seen", int'(seen), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check("midrst_valid", int'(o_syn_valid), 0);
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_ready", int'(o_spike_ready), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    spike(3'd0);
    i_spike_valid = 1'b0;
    row_latency(0, "row0_after_rst");
    wait_idle();

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
